// File: rtl/mcu_sequencer_if.sv
// Sequencer-to-datapath bundle: instruction fetch, next-PC mux, flags,
// data-memory handshake and all decoded control strobes.
// Latency: n/a (wires only). Backpressure: n/a.
// master = the sequencer, slave = instruction memory / datapath side.
// Optional macro MCU_SINGLE_STEP_EN adds the single-step input 'step'.
interface mcu_sequencer_if;
    // inputs to the sequencer
    logic [15:0] imem_data;   // instruction at address pc
    logic [7:0]  pc_next;     // next-PC mux output
    logic        zero_flag;   // ALU zero flag
    logic        neg_flag;    // ALU negative flag
    logic        mem_ready;   // data-memory completion pulse
`ifdef MCU_SINGLE_STEP_EN
    logic        step;        // start one instruction (sampled in WAIT)
`endif
    // outputs from the sequencer
    logic [7:0]  pc;          // instruction-memory address
    logic [7:0]  pc_minus1;   // address of the instruction in the IR
    logic [2:0]  DA;          // destination register field
    logic [2:0]  AA;          // source A register field
    logic [2:0]  BA;          // source B register field
    logic        MA;          // operand A select, 1 = pc_minus1
    logic        MB;          // operand B select, 1 = constant unit
    logic [1:0]  BS;          // next-PC select
    logic [3:0]  FS;          // ALU function code
    logic        RW;          // register write strobe
    logic        MD;          // write-back select, 1 = memory data
    logic        MW;          // memory write
    logic        mem_req;     // data-memory request
    logic        halted;      // core stopped
    logic        bus_err;     // sticky memory-timeout error

    modport master (
`ifdef MCU_SINGLE_STEP_EN
        input  step,
`endif
        input  imem_data, pc_next, zero_flag, neg_flag, mem_ready,
        output pc, pc_minus1, DA, AA, BA, MA, MB, BS, FS,
        output RW, MD, MW, mem_req, halted, bus_err
    );

    modport slave (
`ifdef MCU_SINGLE_STEP_EN
        output step,
`endif
        output imem_data, pc_next, zero_flag, neg_flag, mem_ready,
        input  pc, pc_minus1, DA, AA, BA, MA, MB, BS, FS,
        input  RW, MD, MW, mem_req, halted, bus_err
    );
endinterface

// File: rtl/mcu_sequencer.sv
// Instruction sequencer / control unit for the 8-bit MCU: PC, pc_minus1, IR, decode.
// Latency: 2 cycles per instruction (FETCH, EXEC); LD/ST add >= 1 MEM cycle.
// Backpressure: stalls in MEM until mem_ready; after MEM_TIMEOUT cycles sets bus_err and halts.
// Ports: clk, reset (async, active-high) and 'bus' (mcu_sequencer_if.master) carrying
// imem_data/pc_next/flags/mem_ready in and pc/pc_minus1/DA/AA/BA/MA/MB/BS/FS/RW/MD/MW/
// mem_req/halted/bus_err out. Optional macro MCU_SINGLE_STEP_EN adds bus.step and a
// WAIT state ahead of every FETCH.
module mcu_sequencer #(
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter int         MEM_TIMEOUT = 15      // 1..255
) (
    input  logic            clk,
    input  logic            reset,
    mcu_sequencer_if.master bus
);

`ifdef MCU_SINGLE_STEP_EN
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_EXEC = 3'd1, S_MEM = 3'd2, S_HALT = 3'd3, S_WAIT = 3'd4
    } state_t;
    // every instruction begins and ends in WAIT
    localparam state_t S_START = S_WAIT;
`else
    typedef enum logic [1:0] {
        S_FETCH = 2'd0, S_EXEC = 2'd1, S_MEM = 2'd2, S_HALT = 2'd3
    } state_t;
    localparam state_t S_START = S_FETCH;
`endif

    localparam logic [3:0] OP_LD  = 4'h7;
    localparam logic [3:0] OP_ST  = 4'h8;
    // counter holds (MEM cycles already spent); the last permitted cycle sees MEM_TIMEOUT-1
    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_pc;
    logic [7:0]  r_pc_minus1;
    logic [15:0] r_ir;
    logic [7:0]  r_cnt;
    logic        r_bus_err;

    logic [3:0]  w_op;
    logic        w_ir_load, w_pc_load, w_cnt_inc, w_cnt_clr, w_err_set;
    logic        w_ma, w_mb, w_rw, w_md, w_mw, w_req, w_halted;
    logic [1:0]  w_bs;
    logic [3:0]  w_fs;
    logic        w_unused_ir;

    assign w_op = r_ir[15:12];
    // low IR bits feed the external constant unit straight from imem, not from here
    assign w_unused_ir = ^r_ir[2:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_START;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ir_load   = 1'b0;
        w_pc_load   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_err_set   = 1'b0;
        w_ma        = 1'b0;
        w_mb        = 1'b0;
        w_bs        = 2'b00;
        w_fs        = 4'b0000;
        w_rw        = 1'b0;
        w_md        = 1'b0;
        w_mw        = 1'b0;
        w_req       = 1'b0;
        w_halted    = 1'b0;
        case (r_state)
`ifdef MCU_SINGLE_STEP_EN
            S_WAIT: begin
                if (bus.step) w_state_nxt = S_FETCH;
            end
`endif
            S_FETCH: begin
                w_ir_load   = 1'b1;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // the common case: take the mux output and start the next instruction
                w_pc_load   = 1'b1;
                w_state_nxt = S_START;
                case (w_op)
                    4'h1: begin w_fs = 4'b0010; w_rw = 1'b1; end
                    4'h2: begin w_fs = 4'b0101; w_rw = 1'b1; end
                    4'h3: begin w_fs = 4'b1000; w_rw = 1'b1; end
                    4'h4: begin w_fs = 4'b1001; w_rw = 1'b1; end
                    4'h5: begin w_fs = 4'b0010; w_mb = 1'b1; w_rw = 1'b1; end
                    4'h6: begin w_ma = 1'b1; w_rw = 1'b1; end
                    OP_LD: begin
                        w_req = 1'b1; w_pc_load = 1'b0; w_state_nxt = S_MEM;
                    end
                    OP_ST: begin
                        w_req = 1'b1; w_mw = 1'b1; w_pc_load = 1'b0; w_state_nxt = S_MEM;
                    end
                    4'h9: w_bs = 2'b10;
                    4'hA: w_bs = bus.zero_flag ? 2'b01 : 2'b00;
                    4'hB: w_bs = bus.neg_flag  ? 2'b11 : 2'b00;
                    4'hF: begin w_pc_load = 1'b0; w_state_nxt = S_HALT; end
                    default: ;  // NOP and unused opcodes C/D/E
                endcase
            end
            S_MEM: begin
                w_req = 1'b1;
                w_mw  = (w_op == OP_ST);
                if (bus.mem_ready) begin
                    w_rw        = (w_op == OP_LD);
                    w_md        = (w_op == OP_LD);
                    w_pc_load   = 1'b1;   // BS stays 00 so the mux supplies pc+1
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_START;
                end else if (r_cnt == CNT_LAST) begin
                    w_err_set   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_cnt_inc   = 1'b1;
                end
            end
            S_HALT: w_halted = 1'b1;
            default: w_state_nxt = S_START;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_pc_minus1 <= 8'h00;
            r_ir        <= 16'h0000;
            r_cnt       <= 8'h00;
            r_bus_err   <= 1'b0;
        end else begin
            if (w_ir_load) begin
                r_ir        <= bus.imem_data;
                r_pc_minus1 <= r_pc;
            end
            if (w_pc_load) r_pc <= bus.pc_next;
            if (w_cnt_clr)      r_cnt <= 8'h00;
            else if (w_cnt_inc) r_cnt <= r_cnt + 8'h01;
            if (w_err_set) r_bus_err <= 1'b1;
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_minus1 = r_pc_minus1;
    assign bus.DA        = r_ir[11:9];
    assign bus.AA        = r_ir[8:6];
    assign bus.BA        = r_ir[5:3];
    assign bus.MA        = w_ma;
    assign bus.MB        = w_mb;
    assign bus.BS        = w_bs;
    assign bus.FS        = w_fs;
    assign bus.RW        = w_rw;
    assign bus.MD        = w_md;
    assign bus.MW        = w_mw;
    assign bus.mem_req   = w_req;
    assign bus.halted    = w_halted;
    assign bus.bus_err   = r_bus_err;

endmodule

// File: doc/mcu_sequencer.md
Name: mcu_sequencer

Overview:
- Instruction sequencer and control unit for the 8-bit MCU datapath.
- Owns the PC, PC-of-current-instruction (pc_minus1) and instruction registers.
- Decodes each instruction and drives the operand-mux selects MA and MB, the next-PC select BS, the ALU function code and the register-file and memory strobes.
- Sits between instruction memory, the next-PC mux and the register file/ALU/data-memory path; loads the next-PC mux output into the PC once per instruction.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- MEM_TIMEOUT, 15, maximum cycles to wait for mem_ready before a bus error; valid range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- imem_data  in  16  instruction at address pc (combinational instruction memory).
- pc_next  in  8  next-PC mux output (computed from BS).
- zero_flag  in  1  ALU zero flag for the current instruction.
- neg_flag  in  1  ALU negative flag for the current instruction.
- mem_ready  in  1  data-memory completion, 1-cycle pulse.
- pc  out  8  address to instruction memory.
- pc_minus1  out  8  address of the instruction in the IR.
- DA, AA, BA  out  3 each  destination, source A and source B register fields.
- MA  out  1  operand-A select: 1 = pc_minus1.
- MB  out  1  operand-B select: 1 = constant unit.
- BS  out  2  next-PC select: 00 = +1, 10 = RAA, 01/11 = branch target.
- FS  out  4  ALU function code.
- RW  out  1  register write strobe.
- MD  out  1  write-back select: 1 = memory data.
- MW  out  1  memory write.
- mem_req  out  1  data-memory request.
- halted  out  1  core stopped.
- bus_err  out  1  sticky memory-timeout error.

Behaviour:
- Reset (async, takes effect immediately):
  - pc = RESET_PC; pc_minus1 = 0; IR = 0.
  - All other outputs = 0; state = FETCH; timeout counter = 0.
- Instruction format:
  - opcode = imem_data[15:12]; DA = [11:9]; AA = [8:6]; BA = [5:3].
  - The constant unit uses [5:0] externally.
- States: FETCH, EXEC, MEM, HALT.
- FETCH (1 cycle):
  - IR <= imem_data; pc_minus1 <= pc; next state EXEC.
  - All strobes 0; BS = 00.
- EXEC, decoded from IR opcode (MA, MB, BS, FS, RW, MD, MW valid for this cycle only; 0/00 in all other states):
  - 0 NOP: RW = 0.
  - 1 ADD: FS = 0010, RW = 1.
  - 2 SUB: FS = 0101, RW = 1.
  - 3 AND: FS = 1000, RW = 1.
  - 4 OR: FS = 1001, RW = 1.
  - 5 ADDI: FS = 0010, MB = 1, RW = 1.
  - 6 LPC: MA = 1, FS = 0000 (pass A), RW = 1.
  - 7 LD: mem_req = 1, go to MEM.
  - 8 ST: mem_req = 1, MW = 1, go to MEM.
  - 9 JMP: BS = 10.
  - A BZ: BS = 01 if zero_flag, else 00.
  - B BN: BS = 11 if neg_flag, else 00.
  - F HLT: go to HALT.
  - C, D, E are treated as NOP.
- PC load and latency:
  - Non-memory opcodes except HLT: pc <= pc_next at the end of EXEC, next state FETCH.
  - Result: 2 cycles per instruction.
- MEM state:
  - mem_req (and MW for ST) held high; counter increments each cycle.
  - On mem_ready: LD asserts RW = 1 and MD = 1 that cycle; pc <= pc_next with BS = 00; counter cleared; go to FETCH. Memory instructions take ≥3 cycles.
  - If the counter reaches MEM_TIMEOUT without mem_ready: bus_err <= 1, mem_req drops, go to HALT, PC unchanged.
  - mem_ready outside MEM is ignored.
- HALT: halted = 1; all strobes 0; PC frozen; leave only via reset.
- PC wrap: 8'hFF + 1 = 8'h00 (handled by the next-PC mux; the sequencer loads the value unmodified).

Optional Feature:
- Macro: MCU_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit) and a state WAIT ahead of FETCH.
  - Each instruction starts only on a step pulse sampled in WAIT; after completion the FSM returns to WAIT.
  - Reset enters WAIT.
  - A step asserted during FETCH, EXEC or MEM is ignored.
  - halted is not asserted in WAIT.
- When undefined: no step port; FETCH follows completion directly.

Test Plan:
- Reset with RESET_PC = 8'h10, imem ADD R1,R2,R3 -> first FETCH pc = 10; EXEC FS = 0010, RW = 1, DA = 1, AA = 2, BA = 3; pc = 11 two cycles after reset release.
- BZ with zero_flag = 1, pc_next = 8'h40 -> BS = 01 in EXEC, pc = 40; repeat with zero_flag = 0 -> BS = 00, pc = pc+1.
- LD with mem_ready arriving 3 cycles after EXEC -> mem_req high 4 cycles, RW = 1 and MD = 1 only in the mem_ready cycle; pc advances once.
- ST with mem_ready never asserted, MEM_TIMEOUT = 15 -> bus_err = 1 and halted = 1 after 15 MEM cycles; mem_req = 0; pc unchanged.
- LPC at pc = 8'h22 -> MA = 1, pc_minus1 = 22, RW = 1 in EXEC.
- Reset asserted mid-MEM -> mem_req drops the same cycle; all outputs 0; pc = RESET_PC; bus_err cleared.
